// File: rtl/bounce_engine_pkg.sv
// bounce_pkg: shared types and constants for the bouncing-box motion engine.
//   - screen/box geometry and the derived wall limits MAX_X / MAX_Y
//   - FSM state enum and per-axis direction enum
//   - 8-entry RGB222 palette indexed by the colour index
package bounce_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BOX_W    = 32;
  localparam int BOX_H    = 32;

  // Largest legal top-left coordinate on each axis.
  localparam int MAX_X = H_ACTIVE - BOX_W;
  localparam int MAX_Y = V_ACTIVE - BOX_H;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_X  = 2'd1,
    UPD_Y  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  // RGB222 colours, {R[1:0], G[1:0], B[1:0]}.
  localparam logic [5:0] palette [8] = '{
    6'b110000,  // red
    6'b111100,  // yellow
    6'b001100,  // green
    6'b001111,  // cyan
    6'b000011,  // blue
    6'b110011,  // magenta
    6'b111111,  // white
    6'b100100   // dim orange
  };

endpackage

// File: rtl/bounce_engine_if.sv
// bounce_engine_if: control inputs and box outputs of the motion engine.
//   master: frame/step source and renderer side (drives ena, frame_tick,
//           speed, pause, step; observes the box state)
//   slave : the engine (drives box_x, box_y, colour, hit_x, hit_y, busy,
//           overrun)
interface bounce_engine_if;

  logic       ena;
  logic       frame_tick;
  logic [2:0] speed;
  logic       pause;
  logic       step;

  logic [9:0] box_x;
  logic [9:0] box_y;
  logic [5:0] colour;
  logic       hit_x;
  logic       hit_y;
  logic       busy;
  logic       overrun;

  modport master (
    output ena, frame_tick, speed, pause, step,
    input  box_x, box_y, colour, hit_x, hit_y, busy, overrun
  );

  modport slave (
    input  ena, frame_tick, speed, pause, step,
    output box_x, box_y, colour, hit_x, hit_y, busy, overrun
  );

endinterface

// File: rtl/bounce_engine_axis_step.sv
// axis_step: one-axis position update, purely combinational.
//   p, dir, step, max -> p_next, dir_next, hit
// Moving positive the box clamps to max when it reaches or passes it;
// moving negative it clamps to 0 when it reaches or passes it. A clamp
// flips the direction and raises hit. Shared by both axes in the top.
module axis_step
  import bounce_pkg::*;
(
  input  logic [9:0] p,
  input  dir_t       dir,
  input  logic [3:0] step,
  input  logic [9:0] max,
  output logic [9:0] p_next,
  output dir_t       dir_next,
  output logic       hit
);

  // One extra bit so p + step cannot wrap before the compare.
  logic [10:0] sum;

  always_comb begin
    sum      = {1'b0, p} + {7'b0, step};
    p_next   = p;
    dir_next = dir;
    hit      = 1'b0;
    if (dir == DIR_POS) begin
      if (sum >= {1'b0, max}) begin
        p_next   = max;
        dir_next = DIR_NEG;
        hit      = 1'b1;
      end else begin
        p_next = sum[9:0];
      end
    end else begin
      if (p <= {6'b0, step}) begin
        p_next   = '0;
        dir_next = DIR_POS;
        hit      = 1'b1;
      end else begin
        p_next = p - {6'b0, step};
      end
    end
  end

endmodule

// File: rtl/bounce_engine.sv
// bounce_engine: per-frame box motion for the bouncing-box demo.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   bus        : bounce_engine_if.slave
//                in : ena, frame_tick, speed[2:0], pause, step
//                out: box_x[9:0], box_y[9:0], colour[5:0], hit_x, hit_y,
//                     busy, overrun
// An accepted tick walks IDLE -> UPD_X -> UPD_Y -> COMMIT. The x and y
// results are built in shadow registers and all published together at
// the COMMIT edge, so the renderer never sees a half-updated box.
module bounce_engine
  import bounce_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  bounce_engine_if.slave   bus
);

  localparam logic [9:0] LIM_X = 10'(MAX_X);
  localparam logic [9:0] LIM_Y = 10'(MAX_Y);

  state_t     state, state_nxt;

  logic [9:0] box_x_r, box_y_r;
  dir_t       dir_x_r, dir_y_r;
  logic [2:0] colour_idx_r;
  logic       hit_x_r, hit_y_r;
  logic       overrun_r;
  logic       step_pending_r;
  logic [3:0] step_r;

  logic [9:0] x_sh, y_sh;
  dir_t       dx_sh, dy_sh;
  logic       hx_sh, hy_sh;

  logic       accept;
  logic       commit;

  logic [9:0] ax_p, ax_max, ax_p_next;
  dir_t       ax_dir, ax_dir_next;
  logic       ax_hit;

  // Paused ticks only go through when a single-step has been armed.
  assign accept = bus.ena && bus.frame_tick && (state == IDLE) &&
                  (!bus.pause || step_pending_r);
  assign commit = bus.ena && (state == COMMIT);

  // Single adder/comparator, steered to y during UPD_Y and x otherwise.
  assign ax_p   = (state == UPD_Y) ? box_y_r : box_x_r;
  assign ax_dir = (state == UPD_Y) ? dir_y_r : dir_x_r;
  assign ax_max = (state == UPD_Y) ? LIM_Y   : LIM_X;

  axis_step u_axis (
    .p        (ax_p),
    .dir      (ax_dir),
    .step     (step_r),
    .max      (ax_max),
    .p_next   (ax_p_next),
    .dir_next (ax_dir_next),
    .hit      (ax_hit)
  );

  always_comb begin
    state_nxt = state;
    if (!bus.ena) begin
      // Dropping ena abandons any update in flight.
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nxt = UPD_X;
        UPD_X:   state_nxt = UPD_Y;
        UPD_Y:   state_nxt = COMMIT;
        COMMIT:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x_r        <= '0;
      box_y_r        <= '0;
      dir_x_r        <= DIR_POS;
      dir_y_r        <= DIR_POS;
      colour_idx_r   <= '0;
      hit_x_r        <= 1'b0;
      hit_y_r        <= 1'b0;
      overrun_r      <= 1'b0;
      step_pending_r <= 1'b0;
      step_r         <= 4'd1;
      x_sh           <= '0;
      y_sh           <= '0;
      dx_sh          <= DIR_POS;
      dy_sh          <= DIR_POS;
      hx_sh          <= 1'b0;
      hy_sh          <= 1'b0;
    end else begin
      // Hit flags are single-cycle pulses following the commit edge.
      hit_x_r <= commit ? hx_sh : 1'b0;
      hit_y_r <= commit ? hy_sh : 1'b0;

      if (bus.ena && bus.frame_tick && (state != IDLE))
        overrun_r <= 1'b1;

      if (accept)
        step_r <= {1'b0, bus.speed} + 4'd1;

      if (bus.ena && (state == UPD_X)) begin
        x_sh  <= ax_p_next;
        dx_sh <= ax_dir_next;
        hx_sh <= ax_hit;
      end

      if (bus.ena && (state == UPD_Y)) begin
        y_sh  <= ax_p_next;
        dy_sh <= ax_dir_next;
        hy_sh <= ax_hit;
      end

      // A step pulse landing on the commit edge arms the next frame.
      if (commit)
        step_pending_r <= bus.step;
      else if (bus.ena && bus.step)
        step_pending_r <= 1'b1;

      if (commit) begin
        box_x_r <= x_sh;
        box_y_r <= y_sh;
        dir_x_r <= dx_sh;
        dir_y_r <= dy_sh;
        // A corner hit still advances the colour by one.
        if (hx_sh || hy_sh)
          colour_idx_r <= colour_idx_r + 3'd1;
      end
    end
  end

  assign bus.box_x   = box_x_r;
  assign bus.box_y   = box_y_r;
  assign bus.colour  = palette[colour_idx_r];
  assign bus.hit_x   = hit_x_r;
  assign bus.hit_y   = hit_y_r;
  assign bus.busy    = (state != IDLE);
  assign bus.overrun = overrun_r;

endmodule

// File: doc/bounce_engine.md
# bounce_engine

Per-frame motion engine for the bouncing-box VGA demo. On each frame tick it advances the box position by a programmable step. When the box touches a screen edge it clamps the position, reverses direction and advances the box colour. It sits directly upstream of the pixel renderer inside `tt_um_example`, and feeds it stable box coordinates and a colour that change only between frames.

## Interface
- `H_ACTIVE`, 640: visible width in pixels.
- `V_ACTIVE`, 480: visible height in lines.
- `BOX_W`, 32: box width in pixels.
- `BOX_H`, 32: box height in lines.
- `clk` in 1: system clock (pixel clock).
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: design enable; when low, ticks are ignored and all state holds.
- `frame_tick` in 1: one-cycle pulse at start of vertical blanking.
- `speed` in 3: step size minus one; step = `speed`+1 (1..8 px/frame); sampled on the accepted tick.
- `pause` in 1: level; while high, ticks move nothing unless a step is pending.
- `step` in 1: one-cycle pulse (debounced upstream); arms a single-frame advance.
- `box_x` out 10: left edge of box, 0..`H_ACTIVE`-`BOX_W`.
- `box_y` out 10: top edge of box, 0..`V_ACTIVE`-`BOX_H`.
- `colour` out 6: RGB222 box colour, `palette[colour_idx]`.
- `hit_x` out 1: one-cycle pulse, left/right wall hit committed this frame.
- `hit_y` out 1: one-cycle pulse, top/bottom wall hit committed this frame.
- `busy` out 1: high while an update is in flight.
- `overrun` out 1: sticky; a tick arrived while busy. Cleared only by reset.

## Operation
- Reset values: `box_x`=0, `box_y`=0, dir_x=+, dir_y=+, colour_idx=0, `hit_x`=`hit_y`=0, `busy`=0, `overrun`=0, step_pending=0, FSM=IDLE.
- FSM states: IDLE → UPD_X → UPD_Y → COMMIT → IDLE.
- In IDLE, a tick is accepted when `ena`=1 and (`pause`=0 or step_pending=1). Acceptance latches step=`speed`+1 and moves to UPD_X.
- A tick with `pause`=1 and no pending step is dropped. The FSM stays in IDLE.
- UPD_X computes next_x/dir_x/hx into shadow registers. UPD_Y does the same for y. COMMIT copies the shadows to the outputs.
- Axis rule, positive direction, with MAX = ACTIVE-SIZE:
  - n = p + step, computed at 11 bits.
  - If n ≥ MAX: p = MAX, direction becomes negative, hit = 1.
  - Otherwise p = n.
- Axis rule, negative direction:
  - If p ≤ step: p = 0, direction becomes positive, hit = 1.
  - Otherwise p = p − step.
- Landing exactly on a wall counts as a hit.
- Colour: colour_idx increments by 1 (mod 8) at COMMIT if `hit_x` or `hit_y` is set. A corner hit on both axes still advances it by 1 only.
- `step` pulse sets step_pending. Step_pending is cleared at COMMIT of any accepted update. A `step` pulse arriving in the same cycle as that COMMIT remains pending.
- A tick while `busy`=1 is ignored and sets `overrun`.
- `ena` low: the FSM is forced to IDLE at the next edge, any in-flight update is discarded, and outputs hold.
- Reset mid-update asynchronously restores all reset values. No partial commit is visible.

## Timing
- Tick sampled high at edge T. Then UPD_X runs at T+1, UPD_Y at T+2, COMMIT at T+3.
- `box_x`, `box_y`, `colour`, `hit_x` and `hit_y` change together and only at edge T+3. Hit pulses are high for exactly the cycle after T+3.
- `busy` is high from after edge T through after edge T+3. It is low again after T+3, so a new tick is acceptable at T+4.
- Outputs are registered with no combinational path from inputs. The update completes well inside vertical blanking.

## Structure
- Package `bounce_pkg`:
  - FSM state enum.
  - 8-entry RGB222 `palette` constant, with entry 0 = 6'b110000.
  - Helper localparams MAX_X and MAX_Y.
- Sub-module `axis_step`: combinational, taking (p, dir, step, max) and returning (p_next, dir_next, hit). It is instantiated once and time-shared between UPD_X and UPD_Y, so one adder/comparator serves both axes.

## Test plan
- Reset: assert `rst_n`=0 → `box_x`=0, `box_y`=0, `colour`=6'b110000, `busy`=0, `overrun`=0.
- Basic move: `speed`=3, single tick → exactly 3 cycles later `box_x`=4, `box_y`=4, no hit pulses.
- Walls: `speed`=3, ticks every 8 cycles → tick 112 gives `box_y`=448 with a `hit_y` pulse and colour_idx 1. Tick 113 gives `box_y`=444. Tick 152 gives `box_x`=608 with `hit_x` and colour_idx 2. Tick 153 gives `box_x`=604.
- Pause/step: `pause`=1 with 5 ticks → no change. Then a `step` pulse and one tick → exactly one advance. A further tick → no change.
- Overrun: tick, then a second tick 2 cycles later → the second is ignored, `overrun`=1, and position advances once only.
- Reset mid-update: `rst_n` low during UPD_Y → immediately reset values, no hit pulse, and the FSM restarts cleanly on the next tick.
